rv32i_fde_unit: RTL and testbench

- Multi-cycle RV32I fetch/decode/execute unit. It is the control and datapath heart of the core.
- Sequences every instruction through a 4-state FSM: FETCH, DECODE, EXEC, WRITE.
- Instruction memory and the register file are external. The unit drives their address and write ports and owns the PC.

---
 rtl/rv32i_fde_pkg.sv | 73 +++++++
 rtl/rv32i_fde_decoder.sv | 88 ++++++++
 rtl/rv32i_fde_unit.sv | 173 +++++++++++++++++
 tb/tb_rv32i_fde_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_fde_pkg.sv
// Shared types and constants for the multi-cycle RV32I fetch/decode/execute unit.
// FDE_MUL_EN adds a decoded MUL flag path; the flag exists in every build.
package rv32i_fde_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Exactly one flag is set for any instruction word.
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic op_imm;
    logic op;
    logic mul;
    logic illegal;
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [2:0]        funct3;
    logic              alt;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   imm;
  } dec_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_fde_decoder.sv
// Combinational RV32I decoder: instruction word to one-hot op flags, fields and immediate.
// MUL is recognised only when FDE_MUL_EN is defined; otherwise it decodes as illegal.
module rv32i_fde_decoder
  import rv32i_fde_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output dec_t            o_dec
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_imm_i  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'h000};
  assign w_imm_j  = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};

  always_comb begin
    o_dec        = '0;
    o_dec.funct3 = w_f3;
    o_dec.alt    = i_instr[30];
    o_dec.rd     = i_instr[11:7];
    o_dec.rs1    = i_instr[19:15];
    o_dec.rs2    = i_instr[24:20];
    case (w_opcode)
      OPC_LUI: begin
        o_dec.op.lui = 1'b1;
        o_dec.imm    = w_imm_u;
      end
      OPC_AUIPC: begin
        o_dec.op.auipc = 1'b1;
        o_dec.imm      = w_imm_u;
      end
      OPC_JAL: begin
        o_dec.op.jal = 1'b1;
        o_dec.imm    = w_imm_j;
      end
      OPC_JALR: begin
        o_dec.imm = w_imm_i;
        if (w_f3 == F3_JALR) o_dec.op.jalr    = 1'b1;
        else                 o_dec.op.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        o_dec.imm = w_imm_b;
        if (w_f3 == F3_SLT || w_f3 == F3_SLTU) o_dec.op.illegal = 1'b1;
        else                                   o_dec.op.branch  = 1'b1;
      end
      OPC_OP_IMM: begin
        // Shift-immediates reuse funct7 as an encoding field, so it must be valid.
        o_dec.imm = w_imm_i;
        if ((w_f3 == F3_SLL && w_f7 != F7_BASE) ||
            (w_f3 == F3_SRL_SRA && w_f7 != F7_BASE && w_f7 != F7_ALT))
          o_dec.op.illegal = 1'b1;
        else
          o_dec.op.op_imm = 1'b1;
      end
      OPC_OP: begin
        if (w_f7 == F7_BASE ||
            (w_f7 == F7_ALT && (w_f3 == F3_ADD_SUB || w_f3 == F3_SRL_SRA)))
          o_dec.op.op = 1'b1;
`ifdef FDE_MUL_EN
        else if (w_f7 == F7_MULDIV && w_f3 == F3_ADD_SUB)
          o_dec.op.mul = 1'b1;
`endif
        else
          o_dec.op.illegal = 1'b1;
      end
      OPC_STORE: begin
        o_dec.imm        = w_imm_s;
        o_dec.op.illegal = 1'b1;
      end
      default: o_dec.op.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_fde_unit.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXEC/WRITE sequencing, ALU, branch unit and PC.
// Defining FDE_MUL_EN adds single-cycle MUL (low 32 bits) in the EXEC state.
module rv32i_fde_unit
  import rv32i_fde_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [REG_AW-1:0] rs1_a,
  output logic [REG_AW-1:0] rs2_a,
  input  logic [XLEN-1:0]   rs1_v,
  input  logic [XLEN-1:0]   rs2_v,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_wa,
  output logic [XLEN-1:0]   reg_wd,
  output logic [XLEN-1:0]   pc,
  output logic [1:0]        state,
  output logic              illegal
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc_instr;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   r_target;
  logic              r_taken;
  logic              r_illegal;
  logic              r_reg_we;
  logic [REG_AW-1:0] r_reg_wa;
  logic [XLEN-1:0]   r_reg_wd;

  logic [XLEN-1:0]   w_src;
  dec_t              w_dec;
  logic [XLEN-1:0]   w_op_b;
  logic [XLEN-1:0]   w_sra;
  logic              w_slt;
  logic              w_sltu;
  logic              w_lt;
  logic              w_ltu;
  logic              w_eq;
  logic              w_cond;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_result;
  logic              w_taken;
  logic [XLEN-1:0]   w_target;
  logic              w_writes;

  // Decode the fresh memory word in DECODE so rs1_a/rs2_a are valid that cycle.
  assign w_src = (r_state == ST_DECODE) ? imem_rdata : r_instr;

  rv32i_fde_decoder u_decoder (
    .i_instr (w_src),
    .o_dec   (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rstn) r_state <= ST_FETCH;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:  w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC:   w_state_nxt = ST_WRITE;
      ST_WRITE:  w_state_nxt = ST_FETCH;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  assign w_op_b = w_dec.op.op_imm ? w_dec.imm : rs2_v;
  assign w_sra  = $signed(rs1_v) >>> w_op_b[4:0];
  assign w_slt  = $signed(rs1_v) < $signed(w_op_b);
  assign w_sltu = rs1_v < w_op_b;
  assign w_lt   = $signed(rs1_v) < $signed(rs2_v);
  assign w_ltu  = rs1_v < rs2_v;
  assign w_eq   = rs1_v == rs2_v;

  always_comb begin
    w_alu = '0;
    case (w_dec.funct3)
      F3_ADD_SUB: w_alu = (w_dec.op.op && w_dec.alt) ? rs1_v - w_op_b : rs1_v + w_op_b;
      F3_SLL:     w_alu = rs1_v << w_op_b[4:0];
      F3_SLT:     w_alu = {{(XLEN-1){1'b0}}, w_slt};
      F3_SLTU:    w_alu = {{(XLEN-1){1'b0}}, w_sltu};
      F3_XOR:     w_alu = rs1_v ^ w_op_b;
      F3_SRL_SRA: w_alu = w_dec.alt ? w_sra : rs1_v >> w_op_b[4:0];
      F3_OR:      w_alu = rs1_v | w_op_b;
      F3_AND:     w_alu = rs1_v & w_op_b;
      default:    w_alu = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (w_dec.funct3)
      F3_BEQ:  w_cond = w_eq;
      F3_BNE:  w_cond = !w_eq;
      F3_BLT:  w_cond = w_lt;
      F3_BGE:  w_cond = !w_lt;
      F3_BLTU: w_cond = w_ltu;
      F3_BGEU: w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_result = w_alu;
    if (w_dec.op.lui)                      w_result = w_dec.imm;
    else if (w_dec.op.auipc)               w_result = r_pc_instr + w_dec.imm;
    else if (w_dec.op.jal || w_dec.op.jalr) w_result = r_pc_instr + 32'd4;
`ifdef FDE_MUL_EN
    else if (w_dec.op.mul)                 w_result = rs1_v * rs2_v;
`endif
  end

  // Word alignment also covers the JALR bit-0 clear.
  assign w_target = align_word(w_dec.op.jalr ? rs1_v + w_dec.imm : r_pc_instr + w_dec.imm);
  assign w_taken  = w_dec.op.jal || w_dec.op.jalr || (w_dec.op.branch && w_cond);
  assign w_writes = w_dec.op.lui || w_dec.op.auipc || w_dec.op.jal || w_dec.op.jalr ||
                    w_dec.op.op_imm || w_dec.op.op || w_dec.op.mul;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_pc       <= RESET_PC;
      r_pc_instr <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_taken    <= 1'b0;
      r_target   <= '0;
      r_illegal  <= 1'b0;
      r_reg_we   <= 1'b0;
      r_reg_wa   <= '0;
      r_reg_wd   <= '0;
    end else begin
      r_reg_we <= 1'b0;
      case (r_state)
        ST_DECODE: begin
          r_instr    <= imem_rdata;
          r_pc_instr <= r_pc;
        end
        ST_EXEC: begin
          r_taken  <= w_taken;
          r_target <= w_target;
          r_reg_we <= w_writes && (w_dec.rd != '0);
          r_reg_wa <= w_dec.rd;
          r_reg_wd <= w_result;
        end
        ST_WRITE: begin
          r_pc <= r_taken ? r_target : r_pc + 32'd4;
          if (w_dec.op.illegal) r_illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reset arriving during WRITE suppresses the write already queued for that cycle.
  assign reg_we    = r_reg_we & ~rstn;
  assign reg_wa    = r_reg_wa;
  assign reg_wd    = r_reg_wd;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign state     = r_state;
  assign illegal   = r_illegal;
  assign rs1_a     = w_dec.rs1;
  assign rs2_a     = w_dec.rs2;

endmodule

// File: tb/tb_rv32i_fde_unit.sv
// Randomized bench for rv32i_fde_unit against an instruction-level reference model.
// Expectations for the MUL encoding follow FDE_MUL_EN.
module tb_rv32i_fde_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1_a;
  logic [4:0]  rs2_a;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic        reg_we;
  logic [4:0]  reg_wa;
  logic [31:0] reg_wd;
  logic [31:0] pc;
  logic [1:0]  state;
  logic        illegal;

  logic [31:0] rf [32];
  logic [31:0] cur_word;
  logic [31:0] m_pc;
  logic        m_ill;
  int          n_vec = 0;
  int          n_err = 0;

  rv32i_fde_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .rs1_a      (rs1_a),
    .rs2_a      (rs2_a),
    .rs1_v      (rs1_v),
    .rs2_v      (rs2_v),
    .reg_we     (reg_we),
    .reg_wa     (reg_wa),
    .reg_wd     (reg_wd),
    .pc         (pc),
    .state      (state),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign rs1_v = rf[rs1_a];
  assign rs2_v = rf[rs2_a];

  // Synchronous instruction memory returning the word staged for the current fetch.
  always @(posedge clk) imem_rdata <= cur_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one instruction: write enable/data and next PC.
  function automatic void model(input logic [31:0] w, input logic [31:0] ipc,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic we, output logic [31:0] wd,
                                output logic [31:0] npc, output logic ill);
    logic [31:0] ii, ib, iu, ij;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh;
    logic        tk;
    ii  = {{20{w[31]}}, w[31:20]};
    ib  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    iu  = {w[31:12], 12'h000};
    ij  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    f3  = w[14:12];
    f7  = w[31:25];
    sh  = w[24:20];
    we  = 1'b1;
    wd  = 32'h0;
    npc = ipc + 32'd4;
    ill = 1'b0;
    tk  = 1'b0;
    case (w[6:0])
      7'b0110111: wd = iu;
      7'b0010111: wd = ipc + iu;
      7'b1101111: begin wd = ipc + 32'd4; npc = (ipc + ij) & 32'hFFFF_FFFC; end
      7'b1100111: begin
        if (f3 == 3'd0) begin wd = ipc + 32'd4; npc = (a + ii) & 32'hFFFF_FFFC; end
        else ill = 1'b1;
      end
      7'b1100011: begin
        we = 1'b0;
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) <  $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a <  b);
          3'd7: tk = (a >= b);
          default: ill = 1'b1;
        endcase
        if (tk) npc = (ipc + ib) & 32'hFFFF_FFFC;
      end
      7'b0010011: begin
        case (f3)
          3'd0: wd = a + ii;
          3'd2: wd = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: wd = (a < ii) ? 32'd1 : 32'd0;
          3'd4: wd = a ^ ii;
          3'd6: wd = a | ii;
          3'd7: wd = a & ii;
          3'd1: if (f7 == 7'h00) wd = a << sh; else ill = 1'b1;
          default: begin
            if (f7 == 7'h00)      wd = a >> sh;
            else if (f7 == 7'h20) wd = $signed(a) >>> sh;
            else                  ill = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        case ({f7, f3})
          10'h000: wd = a + b;
          10'h100: wd = a - b;
          10'h001: wd = a << b[4:0];
          10'h002: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          10'h003: wd = (a < b) ? 32'd1 : 32'd0;
          10'h004: wd = a ^ b;
          10'h005: wd = a >> b[4:0];
          10'h105: wd = $signed(a) >>> b[4:0];
          10'h006: wd = a | b;
          10'h007: wd = a & b;
`ifdef FDE_MUL_EN
          10'h008: wd = a * b;
`endif
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin we = 1'b0; npc = ipc + 32'd4; end
    if (w[11:7] == 5'd0) we = 1'b0;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'b0110111;
      1: w[6:0] = 7'b0010111;
      2: w[6:0] = 7'b1101111;
      3: begin w[6:0] = 7'b1100111; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
      4: w[6:0] = 7'b1100011;
      5, 6: begin
        w[6:0] = 7'b0010011;
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      7, 8: begin
        w[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      default: ;
    endcase
    return w;
  endfunction

  // Called at a falling edge while the DUT sits in FETCH; returns at the next FETCH.
  task automatic run_instr(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    logic        we, ill;
    logic [31:0] wd, npc;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0;
    if (w[19:15] != 5'd0) rf[w[19:15]] = a;
    if (w[24:20] != 5'd0) rf[w[24:20]] = b;
    model(w, m_pc, rf[w[19:15]], rf[w[24:20]], we, wd, npc, ill);
    cur_word = w;
    chk("fetch_state", 32'(state), 32'd0);
    chk("imem_addr", imem_addr, m_pc);
    @(negedge clk);
    chk("decode_state", 32'(state), 32'd1);
    chk("rs1_a", 32'(rs1_a), 32'(w[19:15]));
    @(negedge clk);
    chk("exec_state", 32'(state), 32'd2);
    chk("rs2_a", 32'(rs2_a), 32'(w[24:20]));
    chk("exec_no_we", 32'(reg_we), 32'd0);
    @(negedge clk);
    chk("write_state", 32'(state), 32'd3);
    chk("reg_we", 32'(reg_we), 32'(we));
    if (we) begin
      chk("reg_wa", 32'(reg_wa), 32'(w[11:7]));
      chk("reg_wd", reg_wd, wd);
    end
    @(negedge clk);
    m_pc  = npc;
    m_ill = m_ill | ill;
    chk("next_pc", pc, m_pc);
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("we_cleared", 32'(reg_we), 32'd0);
  endtask

  initial begin
    rstn     = 1'b1;
    cur_word = 32'h0000_0013;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    m_pc  = RST_PC;
    m_ill = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_we", 32'(reg_we), 32'd0);
    chk("rst_wa", 32'(reg_wa), 32'd0);
    chk("rst_wd", reg_wd, 32'd0);
    rstn = 1'b0;

    run_instr(32'h0050_0093, 32'h0, 32'h0);               // ADDI x1,x0,5
    chk("addi_pc", pc, 32'd4);
    run_instr(32'h0020_81B3, 32'hFFFF_FFFF, 32'd1);       // ADD x3,x1,x2 wraps to 0
    run_instr(32'h00C0_00EF, 32'h0, 32'h0);               // JAL x1,+12 at pc 8
    chk("jal_pc", pc, 32'd20);
    run_instr(32'h4020_01B3, 32'h0, 32'd1);               // SUB x3,x0,x2
    run_instr(32'h0032_8067, 32'd100, 32'h0);             // JALR x0,x5,3
    chk("jalr_pc", pc, 32'd100);
    run_instr(32'h0002_8067, 32'd16, 32'h0);              // JALR x0,x5,0 -> 16
    run_instr(32'hFE20_8CE3, 32'd7, 32'd7);               // BEQ taken
    chk("beq_taken_pc", pc, 32'd8);
    run_instr(32'h0002_8067, 32'd16, 32'h0);
    run_instr(32'hFE20_8CE3, 32'd7, 32'd9);               // BEQ not taken
    chk("beq_fall_pc", pc, 32'd20);
    run_instr(32'h0020_E463, 32'd1, 32'h8000_0000);       // BLTU taken
    chk("bltu_pc", pc, 32'd28);
    run_instr(32'h0020_C463, 32'd1, 32'h8000_0000);       // BLT not taken
    chk("blt_pc", pc, 32'd32);
    run_instr(32'h0220_81B3, 32'h0001_0000, 32'h0001_0000); // MUL x3,x1,x2
`ifdef FDE_MUL_EN
    chk("mul_illegal", 32'(illegal), 32'd0);
`else
    chk("mul_illegal", 32'(illegal), 32'd1);
`endif
    run_instr(32'h0000_2003, 32'h0, 32'h0);               // LOAD: NOP + illegal
    chk("load_illegal", 32'(illegal), 32'd1);

    for (int n = 0; n < 150; n++) run_instr(rand_word(), $urandom, $urandom);

    // Abort an instruction in EXEC with reset.
    cur_word = 32'h0070_0093;
    @(negedge clk);
    @(negedge clk);
    chk("abort_exec_state", 32'(state), 32'd2);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_pc", pc, RST_PC);
    chk("abort_illegal", 32'(illegal), 32'd0);
    chk("abort_we", 32'(reg_we), 32'd0);
    rstn  = 1'b0;
    m_pc  = RST_PC;
    m_ill = 1'b0;

    for (int n = 0; n < 40; n++) run_instr(rand_word(), $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
